// File: rtl/pimc_pkg.sv
// Shared types for the interrupt message dispatcher.
//   pimc_msg_t        captured message (line number + target cpu)
//   dispatch_state_t  capture FSM states
package pimc_pkg;

  localparam logic [7:0] PIMC_DEFAULT_VEC_BASE = 8'h20;

  typedef struct packed {
    logic [7:0] lineno;
    logic [7:0] cpu;
  } pimc_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } dispatch_state_t;

endpackage

// File: rtl/pimc_msg_fifo.sv
// Message FIFO for the dispatcher.
//   push/push_data  write one entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   head            current head entry, zero when storage never written
//   count           occupancy, 0..DEPTH
module pimc_msg_fifo
  import pimc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pimc_msg_t                  push_data,
  input  logic                       pop,
  output pimc_msg_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  pimc_msg_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop  && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pimc_dispatch.sv
// Interrupt message dispatcher downstream of the platform interrupt controller.
// Captures posted messages (notify low), retires them with a one-cycle irqack,
// buffers them and delivers them over a valid/ready handshake.
//   notify/lineno/processor_id  posted message from the controller
//   irqack                      registered retire pulse to the controller
//   out_valid/out_ready         delivery handshake
//   out_vector/out_cpu          VEC_BASE+lineno and cpu of the head entry
//   pending                     FIFO occupancy
//   delivered                   saturating count of completed handshakes
module pimc_dispatch
  import pimc_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] VEC_BASE = PIMC_DEFAULT_VEC_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       notify,
  input  logic [7:0]                 lineno,
  input  logic [7:0]                 processor_id,
  output logic                       irqack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_vector,
  output logic [7:0]                 out_cpu,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [15:0]                delivered
);

  localparam int CW = $clog2(DEPTH + 1);

  dispatch_state_t state_q, state_d;
  logic            irqack_q, irqack_d;
  logic [15:0]     delivered_q, delivered_d;
  logic            push, pop;
  pimc_msg_t       push_msg, head;
  logic [CW-1:0]   count;

  // Full check is on registered occupancy only: a pop this cycle does not
  // make room for a push until the next cycle.
  assign push     = (state_q == IDLE) && !notify && (count != CW'(DEPTH));
  assign pop      = out_valid && out_ready;
  assign push_msg = '{lineno: lineno, cpu: processor_id};

  pimc_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_msg),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d  = state_q;
    irqack_d = 1'b0;
    case (state_q)
      IDLE: if (push) begin
        state_d  = ACK;
        irqack_d = 1'b1;
      end
      ACK:  state_d = WAIT;
      // Hold off until the controller has dropped the retired message.
      WAIT: if (notify) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    delivered_d = delivered_q;
    if (pop && (delivered_q != 16'hFFFF)) delivered_d = delivered_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      irqack_q    <= 1'b0;
      delivered_q <= '0;
    end else begin
      state_q     <= state_d;
      irqack_q    <= irqack_d;
      delivered_q <= delivered_d;
    end
  end

  assign irqack     = irqack_q;
  assign out_valid  = (count != '0);
  assign out_vector = VEC_BASE + head.lineno;
  assign out_cpu    = head.cpu;
  assign pending    = count;
  assign delivered  = delivered_q;

endmodule

// File: tb/tb_pimc_dispatch.sv
module tb_pimc_dispatch;
  import pimc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       notify = 1'b1, out_ready = 1'b0;
  logic [7:0] lineno = '0, processor_id = '0;
  logic       irqack, out_valid;
  logic [7:0] out_vector, out_cpu;
  logic [2:0] pending;
  logic [15:0] delivered;

  logic       notify2 = 1'b1, out_ready2 = 1'b0;
  logic [7:0] lineno2 = '0, processor_id2 = '0;
  logic       irqack2, out_valid2;
  logic [7:0] out_vector2, out_cpu2;
  logic [2:0] pending2;
  logic [15:0] delivered2;

  int vecs = 0;
  int errs = 0;

  pimc_dispatch #(.DEPTH(4), .VEC_BASE(8'h20)) dut (
    .clk(clk), .rst(rst), .notify(notify), .lineno(lineno), .processor_id(processor_id),
    .irqack(irqack), .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .out_cpu(out_cpu), .pending(pending), .delivered(delivered));

  pimc_dispatch #(.DEPTH(4), .VEC_BASE(8'hF0)) dut2 (
    .clk(clk), .rst(rst), .notify(notify2), .lineno(lineno2), .processor_id(processor_id2),
    .irqack(irqack2), .out_valid(out_valid2), .out_ready(out_ready2), .out_vector(out_vector2),
    .out_cpu(out_cpu2), .pending(pending2), .delivered(delivered2));

  // Controller model: post a message, drop notify once irqack is seen, then
  // allow the FSM to return to IDLE. Called and returns at a negedge.
  task automatic post_msg(input logic [7:0] ln, input logic [7:0] cpu, output bit acked);
    acked = 1'b0;
    lineno = ln; processor_id = cpu; notify = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (irqack) acked = 1'b1;
    end
    notify = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vecs++; if (irqack !== 1'b0) begin errs++; $display("FAIL rst_irqack got %b want 0", irqack); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", out_valid); end
    vecs++; if (out_vector !== 8'h20) begin errs++; $display("FAIL rst_vector got %h want 20", out_vector); end
    vecs++; if (out_cpu !== 8'h00) begin errs++; $display("FAIL rst_cpu got %h want 00", out_cpu); end
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL rst_pending got %0d want 0", pending); end
    vecs++; if (delivered !== 16'd0) begin errs++; $display("FAIL rst_delivered got %0d want 0", delivered); end
    vecs++; if (out_vector2 !== 8'hF0) begin errs++; $display("FAIL rst_vector2 got %h want f0", out_vector2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    lineno = 8'd3; processor_id = 8'd1; notify = 1'b0; out_ready = 1'b0;
    vecs++; if (irqack !== 1'b0) begin errs++; $display("FAIL single_pre_ack got %b want 0", irqack); end
    @(negedge clk);
    vecs++; if (irqack !== 1'b1) begin errs++; $display("FAIL single_ack got %b want 1", irqack); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", out_valid); end
    vecs++; if (out_vector !== 8'h23) begin errs++; $display("FAIL single_vector got %h want 23", out_vector); end
    vecs++; if (out_cpu !== 8'h01) begin errs++; $display("FAIL single_cpu got %h want 01", out_cpu); end
    vecs++; if (pending !== 3'd1) begin errs++; $display("FAIL single_pending got %0d want 1", pending); end
    notify = 1'b1;
    @(negedge clk);
    vecs++; if (irqack !== 1'b0) begin errs++; $display("FAIL single_ack_width got %b want 0", irqack); end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL single_pop_pending got %0d want 0", pending); end
    vecs++; if (delivered !== 16'd1) begin errs++; $display("FAIL single_delivered got %0d want 1", delivered); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_empty got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    bit acked, saw;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      post_msg(8'(i), 8'(8'h40 + i), acked);
      vecs++; if (acked !== 1'b1) begin errs++; $display("FAIL bp_ack%0d got %b want 1", i, acked); end
    end
    vecs++; if (pending !== 3'd4) begin errs++; $display("FAIL bp_full got %0d want 4", pending); end
    lineno = 8'd4; processor_id = 8'h44; notify = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (irqack) saw = 1'b1;
    end
    vecs++; if (saw !== 1'b0) begin errs++; $display("FAIL bp_no_ack got %b want 0", saw); end
    vecs++; if (pending !== 3'd4) begin errs++; $display("FAIL bp_held got %0d want 4", pending); end
    vecs++; if (out_vector !== 8'h20) begin errs++; $display("FAIL bp_head0 got %h want 20", out_vector); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (pending !== 3'd3) begin errs++; $display("FAIL bp_pop_pending got %0d want 3", pending); end
    vecs++; if (irqack !== 1'b0) begin errs++; $display("FAIL bp_same_cycle_ack got %b want 0", irqack); end
    @(negedge clk);
    vecs++; if (irqack !== 1'b1) begin errs++; $display("FAIL bp_late_ack got %b want 1", irqack); end
    vecs++; if (pending !== 3'd4) begin errs++; $display("FAIL bp_refill got %0d want 4", pending); end
    notify = 1'b1;
    @(negedge clk); @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vecs++; if (out_vector !== 8'(8'h20 + i)) begin errs++; $display("FAIL bp_order%0d got %h want %h", i, out_vector, 8'(8'h20 + i)); end
      vecs++; if (out_cpu !== 8'(8'h40 + i)) begin errs++; $display("FAIL bp_cpu%0d got %h want %h", i, out_cpu, 8'(8'h40 + i)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL bp_drained got %0d want 0", pending); end
    vecs++; if (delivered !== 16'd6) begin errs++; $display("FAIL bp_delivered got %0d want 6", delivered); end
  endtask

  task automatic test_push_pop();
    bit acked;
    out_ready = 1'b0;
    post_msg(8'h0A, 8'h50, acked);
    post_msg(8'h0B, 8'h51, acked);
    vecs++; if (pending !== 3'd2) begin errs++; $display("FAIL pp_setup got %0d want 2", pending); end
    vecs++; if (out_vector !== 8'h2A) begin errs++; $display("FAIL pp_head got %h want 2a", out_vector); end
    lineno = 8'h0C; processor_id = 8'h52; notify = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (irqack !== 1'b1) begin errs++; $display("FAIL pp_ack got %b want 1", irqack); end
    vecs++; if (pending !== 3'd2) begin errs++; $display("FAIL pp_pending got %0d want 2", pending); end
    vecs++; if (out_vector !== 8'h2B) begin errs++; $display("FAIL pp_advance got %h want 2b", out_vector); end
    vecs++; if (out_cpu !== 8'h51) begin errs++; $display("FAIL pp_cpu got %h want 51", out_cpu); end
    notify = 1'b1;
    @(negedge clk); @(negedge clk);
    out_ready = 1'b1;
    vecs++; if (out_vector !== 8'h2B) begin errs++; $display("FAIL pp_drain0 got %h want 2b", out_vector); end
    @(negedge clk);
    vecs++; if (out_vector !== 8'h2C) begin errs++; $display("FAIL pp_drain1 got %h want 2c", out_vector); end
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL pp_empty got %0d want 0", pending); end
    vecs++; if (delivered !== 16'd9) begin errs++; $display("FAIL pp_delivered got %0d want 9", delivered); end
  endtask

  task automatic test_vec_wrap();
    lineno2 = 8'h15; processor_id2 = 8'h09; notify2 = 1'b0;
    @(negedge clk);
    notify2 = 1'b1;
    vecs++; if (irqack2 !== 1'b1) begin errs++; $display("FAIL wrap_ack got %b want 1", irqack2); end
    vecs++; if (out_valid2 !== 1'b1) begin errs++; $display("FAIL wrap_valid got %b want 1", out_valid2); end
    vecs++; if (out_vector2 !== 8'h05) begin errs++; $display("FAIL wrap_vector got %h want 05", out_vector2); end
    vecs++; if (out_cpu2 !== 8'h09) begin errs++; $display("FAIL wrap_cpu got %h want 09", out_cpu2); end
    vecs++; if (pending2 !== 3'd1) begin errs++; $display("FAIL wrap_pending got %0d want 1", pending2); end
    vecs++; if (delivered2 !== 16'd0) begin errs++; $display("FAIL wrap_delivered got %0d want 0", delivered2); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_saturation();
    bit acked;
    out_ready = 1'b0;
    post_msg(8'h01, 8'h01, acked);
    post_msg(8'h02, 8'h02, acked);
    // Stand in for 65534 prior handshakes.
    force dut.delivered_q = 16'hFFFE;
    #1;
    release dut.delivered_q;
    #1;
    vecs++; if (delivered !== 16'hFFFE) begin errs++; $display("FAIL sat_preload got %h want fffe", delivered); end
    out_ready = 1'b1;
    @(negedge clk);
    vecs++; if (delivered !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got %h want ffff", delivered); end
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (delivered !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got %h want ffff", delivered); end
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL sat_pending got %0d want 0", pending); end
  endtask

  task automatic test_reset_midop();
    bit acked;
    out_ready = 1'b0;
    post_msg(8'h05, 8'h05, acked);
    post_msg(8'h06, 8'h06, acked);
    lineno = 8'h07; processor_id = 8'h07; notify = 1'b0;
    @(negedge clk);
    vecs++; if (irqack !== 1'b1) begin errs++; $display("FAIL mid_ack got %b want 1", irqack); end
    vecs++; if (pending !== 3'd3) begin errs++; $display("FAIL mid_pending got %0d want 3", pending); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (irqack !== 1'b0) begin errs++; $display("FAIL mid_rst_ack got %b want 0", irqack); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    vecs++; if (pending !== 3'd0) begin errs++; $display("FAIL mid_rst_pending got %0d want 0", pending); end
    vecs++; if (delivered !== 16'd0) begin errs++; $display("FAIL mid_rst_delivered got %0d want 0", delivered); end
    vecs++; if (out_vector !== 8'h20) begin errs++; $display("FAIL mid_rst_vector got %h want 20", out_vector); end
    vecs++; if (out_cpu !== 8'h00) begin errs++; $display("FAIL mid_rst_cpu got %h want 00", out_cpu); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (irqack !== 1'b1) begin errs++; $display("FAIL mid_recap_ack got %b want 1", irqack); end
    vecs++; if (pending !== 3'd1) begin errs++; $display("FAIL mid_recap_pending got %0d want 1", pending); end
    vecs++; if (out_vector !== 8'h27) begin errs++; $display("FAIL mid_recap_vector got %h want 27", out_vector); end
    notify = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_push_pop();
    test_vec_wrap();
    test_saturation();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
